// File: rtl/mod_mul_il_radix.sv
// Interleaved MSB-first modular multiplier y = (a*b) mod m, consuming DBITS bits of a per
// clock through an unrolled chain of radix-2 double/add/reduce steps. Latency is fixed at NBITS/DBITS.
module mod_mul_il_radix #(
  parameter int NBITS = 2048,
  parameter int DBITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] y,
  output logic             err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // start_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.

  localparam int NDIG = NBITS / DBITS;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = NBITS + 2;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  generate
    if (DBITS < 1 || DBITS > 4 || (NBITS % DBITS) != 0) begin : g_bad_params
      $error("mod_mul_il_radix: DBITS must be 1..4 and divide NBITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_m;
  logic [NBITS-1:0] r_y;
  logic [PW-1:0]    r_p;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [PW-1:0]    w_p;
  logic             w_accept;
  logic             w_bad;
  logic             w_last;

  assign w_accept = start_valid && (r_state == S_IDLE);
  assign w_bad    = (b >= m) || (m == '0);
  assign w_last   = (r_cnt == LAST_DIG);

  // Each step: P = 2P + d_i*b, then up to two conditional subtractions since P < 3m here.
  always_comb begin
    w_p = r_p;
    for (int i = 0; i < DBITS; i++) begin
      w_p = {w_p[PW-2:0], 1'b0} + (r_a[NBITS-1-i] ? {2'b00, r_b} : '0);
      if (w_p >= {2'b00, r_m}) w_p = w_p - {2'b00, r_m};
      if (w_p >= {2'b00, r_m}) w_p = w_p - {2'b00, r_m};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_bad ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: if (abort || out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_y   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_m   <= m;
            r_p   <= '0;
            r_cnt <= '0;
            if (w_bad) begin
              r_y   <= '0;
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // An aborted operation must leave y and err untouched.
          if (!abort) begin
            r_p   <= w_p;
            r_a   <= r_a << DBITS;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_y   <= w_p[NBITS-1:0];
              r_err <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
  assign y           = r_y;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mod_mul_il_radix.sv
// Bench for mod_mul_il_radix at NBITS=8, DBITS=2: vector table, handshake/abort/reset
// sequences and random legal operands checked against integer arithmetic.
module tb_mod_mul_il_radix;

  localparam int NB   = 8;
  localparam int DB   = 2;
  localparam int NDIG = NB / DB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_valid = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic [NB-1:0] m = '0;
  logic          start_ready;
  logic          out_valid;
  logic          err;
  logic          busy;
  logic [NB-1:0] y;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] exp_q[$];

  mod_mul_il_radix #(.NBITS(NB), .DBITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .m(m), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] va;
    logic [NB-1:0] vb;
    logic [NB-1:0] vm;
    logic [NB-1:0] exp_y;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // driver: present a request and return right after the accepting edge
  task automatic start_op(input logic [NB-1:0] ai, input logic [NB-1:0] bi, input logic [NB-1:0] mi);
    int n = 0;
    while (!start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!start_ready) check("start_ready_wait", {31'd0, start_ready}, 32'd1);
    a = ai; b = bi; m = mi;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // operands are registered, so scrambling the inputs must not matter
    a = NB'($urandom); b = NB'($urandom); m = NB'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    if (!out_valid) check("result_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic ack_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("start_ready_after_ack", {31'd0, start_ready}, 32'd1);
    check("out_valid_after_ack", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_and_check(input string name, input logic [NB-1:0] ai, input logic [NB-1:0] bi,
                               input logic [NB-1:0] mi, input logic [NB-1:0] ey,
                               input logic ee, input int el);
    int lat;
    exp_q.push_back(ey);
    start_op(ai, bi, mi);
    wait_result(lat);
    check({name, "_y"}, {24'd0, y}, {24'd0, exp_q.pop_front()});
    check({name, "_err"}, {31'd0, err}, {31'd0, ee});
    check({name, "_lat"}, lat, el);
    ack_result();
  endtask

  initial begin
    int lat;
    logic seen_valid;
    logic [NB-1:0] held_y;
    int ra, rb, rm;

    vecs[0] = '{8'd7,   8'd5,   8'd11,  8'd2, 1'b0, NDIG};
    vecs[1] = '{8'd255, 8'd10,  8'd13,  8'd2, 1'b0, NDIG};
    vecs[2] = '{8'd0,   8'd3,   8'd7,   8'd0, 1'b0, NDIG};
    vecs[3] = '{8'd11,  8'd11,  8'd11,  8'd0, 1'b1, 1};
    vecs[4] = '{8'd5,   8'd3,   8'd0,   8'd0, 1'b1, 1};
    vecs[5] = '{8'd200, 8'd0,   8'd1,   8'd0, 1'b0, NDIG};
    vecs[6] = '{8'd3,   8'd4,   8'd5,   8'd2, 1'b0, NDIG};
    vecs[7] = '{8'd254, 8'd254, 8'd255, 8'd1, 1'b0, NDIG};
    vecs[8] = '{8'd128, 8'd1,   8'd3,   8'd2, 1'b0, NDIG};

    #12;
    check("reset_start_ready", {31'd0, start_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_y", {24'd0, y}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vm,
                    vecs[i].exp_y, vecs[i].exp_err, vecs[i].exp_lat);

    // backpressure: result and status held while out_ready stays low
    start_op(8'd7, 8'd5, 8'd11);
    wait_result(lat);
    check("bp_lat", lat, NDIG);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_y%0d", i), {24'd0, y}, 32'd2);
      check($sformatf("bp_busy%0d", i), {31'd0, busy}, 32'd1);
      check($sformatf("bp_start_ready%0d", i), {31'd0, start_ready}, 32'd0);
    end
    ack_result();
    check("bp_busy_after_ack", {31'd0, busy}, 32'd0);

    // set y to 1 so the abort checks can see that it is preserved
    run_and_check("pre_abort", 8'd254, 8'd254, 8'd255, 8'd1, 1'b0, NDIG);

    // abort in RUN after two digits
    start_op(8'd7, 8'd5, 8'd11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_start_ready", {31'd0, start_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_y_held", {24'd0, y}, 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", {31'd0, seen_valid}, 32'd0);
    run_and_check("after_abort", 8'd3, 8'd4, 8'd5, 8'd2, 1'b0, NDIG);

    // abort while a result waits in DONE
    run_and_check("pre_done_abort", 8'd254, 8'd254, 8'd255, 8'd1, 1'b0, NDIG);
    start_op(8'd128, 8'd1, 8'd3);
    wait_result(lat);
    check("done_abort_lat", lat, NDIG);
    held_y = y;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("done_abort_valid", {31'd0, out_valid}, 32'd0);
    check("done_abort_start_ready", {31'd0, start_ready}, 32'd1);
    check("done_abort_y", {24'd0, y}, 32'd2);
    check("done_abort_y_stable", {24'd0, y}, {24'd0, held_y});

    // abort together with start in IDLE is ignored
    abort = 1'b1;
    start_op(8'd3, 8'd4, 8'd5);
    abort = 1'b0;
    wait_result(lat);
    check("idle_abort_lat", lat, NDIG);
    check("idle_abort_y", {24'd0, y}, 32'd2);
    ack_result();

    // asynchronous reset in the middle of RUN
    start_op(8'd7, 8'd5, 8'd11);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_y", {24'd0, y}, 32'd0);
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_no_result", {31'd0, seen_valid}, 32'd0);

    // random legal operands against plain integer arithmetic
    for (int i = 0; i < 30; i++) begin
      rm = $urandom_range(255, 1);
      rb = $urandom_range(rm - 1, 0);
      ra = $urandom_range(255, 0);
      run_and_check($sformatf("rand%0d", i), NB'(ra), NB'(rb), NB'(rm),
                    NB'((ra * rb) % rm), 1'b0, NDIG);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_mul_il_radix.md
Name: mod_mul_il_radix

Overview:
- Parametrised successor of the bit-serial interleaved modular multiplier in crypto_lib.
- Computes y = (a*b) mod m by MSB-first interleaved multiply-reduce, DBITS bits of a per clock, via an unrolled chain of radix-2 steps.
- Fixed, data-independent latency (constant-time).
- Valid/ready handshakes on input and output, synchronous abort, operand-range error flag.
- Used by the Paillier exponentiation/encryption datapath.

Parameters:
- NBITS, 2048, operand/modulus width.
- DBITS, 2, bits of a consumed per cycle; legal 1..4; NBITS % DBITS == 0 (elaboration error otherwise).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  request valid; a, b, m sampled when start_valid & start_ready.
- start_ready  out  1  high iff state IDLE.
- a  in  NBITS  multiplier; any value.
- b  in  NBITS  multiplicand; must satisfy b < m.
- m  in  NBITS  modulus; must be nonzero.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- y  out  NBITS  result register.
- err  out  1  qualified by out_valid; 1 = illegal operands (b >= m or m == 0).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous): state=IDLE, y=0, err=0, out_valid=0, busy=0, internal P/a_reg/b_reg/m_reg/cnt=0. start_ready=1 (derived combinationally from state).
- NDIG = NBITS/DBITS. cnt width = clog2(NDIG), minimum 1 bit.
- IDLE:
  - On start_valid & start_ready, latch a/b/m, set P=0, cnt=0.
  - If b >= m or m == 0: go to DONE with err=1, y=0; out_valid rises on that same edge (latency 1).
  - Otherwise go to RUN.
- RUN, each cycle:
  - Take digit d = top DBITS of a_reg.
  - Apply DBITS chained steps, MSB of d first: P = 2P + d_i*b_reg; if P >= m_reg subtract m_reg; repeat the compare/subtract once more.
  - Internal width NBITS+2 (P < 3m before reduction). Invariant after every step: P < m.
  - Shift a_reg left by DBITS; cnt++.
  - When the final digit is processed (cnt == NDIG-1): load y = reduced P, err=0, go to DONE.
  - out_valid rises exactly NDIG edges after the acceptance edge, regardless of operand values, including a=0 and leading zeros. No early termination.
- DONE:
  - out_valid=1; y and err held stable.
  - On out_ready: out_valid=0, go to IDLE. start_ready rises the same edge.
  - A new start cannot be accepted in the cycle out_ready is accepted.
- abort:
  - In RUN or DONE: next edge goes to IDLE, out_valid=0; y and err keep their previous values. No result is emitted for the aborted operation.
  - In IDLE: abort is ignored; a simultaneous start_valid is accepted normally.
- Input changes after acceptance have no effect (operands are registered).
- y holds the last delivered result until the next completion or error overwrites it.
- Reset asserted mid-operation: immediate return to reset values; no out_valid.
- m=1 with b=0: legal, y=0.

Test Plan:
- NBITS=8, DBITS=2; a=7, b=5, m=11 -> out_valid exactly 4 edges after accept, y=2, err=0. Repeat with a=255, b=10, m=13 -> y=2, latency 4. Repeat with a=0, b=3, m=7 -> y=0, latency 4.
- NBITS=8; b=11, m=11 -> out_valid after 1 edge, err=1, y=0. m=0 -> err=1. b=0, m=1, a=200 -> err=0, y=0.
- Backpressure: hold out_ready=0 for 5 cycles after a=7, b=5, m=11 -> out_valid, y=2 and busy stay stable, start_ready=0. Raise out_ready -> IDLE next edge.
- Abort at RUN cycle 2 of a=7, b=5, m=11 -> out_valid never rises, start_ready=1 next edge, y unchanged. Immediate new request a=3, b=4, m=5 -> y=2 after 4 cycles.
- rst_n low mid-RUN -> all outputs reset asynchronously. Abort+start_valid in IDLE -> request accepted.
- Sweep DBITS in {1, 2, 4}, NBITS in {8, 64, 2048}: 1000 random legal triples vs software model -> y exact, latency NBITS/DBITS every time.
